// File: rtl/unum_pkg.sv
// unum_pkg: shared types for the unum FMA arbiter.
// Tag ids are 3 bits wide, enough for up to 8 requesters.
package unum_pkg;
  localparam int UNUM_W      = 32;
  localparam int FMA_LATENCY = 10;
  localparam int ID_W        = 3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DRAINED
  } drain_st_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/unum_rsp_fifo.sv
// unum_rsp_fifo: first-word-fall-through response FIFO.
// Entry layout is {nan, data}; the head reads as zero while empty.
module unum_rsp_fifo
  import unum_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = UNUM_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign valid_o = (cnt_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign dout_o  = valid_o ? mem_q[rptr_q] : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !do_pop) cnt_d = cnt_q + CW'(1);
    else if (!push_i && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= nxt(wptr_q);
      if (do_pop) rptr_q <= nxt(rptr_q);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !do_pop && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/unum_fma_arbiter.sv
// unum_fma_arbiter: round-robin sharing of one fixed-latency unum FMA.
// Define UNUM_FMA_ARB_STATS_EN to add issue/blocked counters.
module unum_fma_arbiter
  import unum_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int LATENCY   = FMA_LATENCY,
  parameter int RSP_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*UNUM_W-1:0] req_a,
  input  logic [NREQ*UNUM_W-1:0] req_b,
  input  logic [NREQ*UNUM_W-1:0] req_c,
  output logic [UNUM_W-1:0]      fma_a,
  output logic [UNUM_W-1:0]      fma_b,
  output logic [UNUM_W-1:0]      fma_c,
  input  logic [UNUM_W-1:0]      fma_result,
  input  logic                   fma_nan,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [NREQ*UNUM_W-1:0] rsp_data,
  output logic [NREQ-1:0]        rsp_nan,
  input  logic                   drain_req,
  output logic                   drain_done
`ifdef UNUM_FMA_ARB_STATS_EN
  ,
  output logic [31:0]            stat_issued,
  output logic [31:0]            stat_blocked
`endif
);
  localparam int CRW  = $clog2(RSP_DEPTH + 1);
  localparam int NMAX = 1 << ID_W;

  drain_st_e         st_q, st_d;
  tag_t              tag_q [LATENCY+1];
  tag_t              tag_in;
  logic [ID_W-1:0]   rr_q, rr_d, win, idx;
  logic [NMAX-1:0]   elig;
  logic [UNUM_W-1:0] a_v [NMAX];
  logic [UNUM_W-1:0] b_v [NMAX];
  logic [UNUM_W-1:0] c_v [NMAX];
  logic              accept, busy;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    logic [CRW-1:0] cred_q;
    logic [UNUM_W:0] head;
    logic iss, pop, push;

    assign a_v[i]  = req_a[i*UNUM_W +: UNUM_W];
    assign b_v[i]  = req_b[i*UNUM_W +: UNUM_W];
    assign c_v[i]  = req_c[i*UNUM_W +: UNUM_W];
    assign elig[i] = req_valid[i] && (cred_q != '0) && (st_q == ST_RUN);
    assign iss     = accept && (win == ID_W'(i));
    assign pop     = rsp_valid[i] && rsp_ready[i];
    assign push    = tag_q[LATENCY].valid && (tag_q[LATENCY].id == ID_W'(i));

    // Issue and pop in the same cycle cancel out.
    always_ff @(posedge clk) begin
      if (rst) cred_q <= CRW'(RSP_DEPTH);
      else if (iss && !pop) cred_q <= cred_q - CRW'(1);
      else if (!iss && pop) cred_q <= cred_q + CRW'(1);
    end

    unum_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .W     (UNUM_W + 1)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   ({fma_nan, fma_result}),
      .pop_i   (pop),
      .dout_o  (head),
      .valid_o (rsp_valid[i])
    );

    assign rsp_data[i*UNUM_W +: UNUM_W] = head[UNUM_W-1:0];
    assign rsp_nan[i] = head[UNUM_W];

    a_cred_max: assert property (@(posedge clk) disable iff (rst)
      cred_q <= CRW'(RSP_DEPTH));
  end

  for (genvar i = NREQ; i < NMAX; i++) begin : g_pad
    assign elig[i] = 1'b0;
    assign a_v[i]  = '0;
    assign b_v[i]  = '0;
    assign c_v[i]  = '0;
  end

  always_comb begin
    accept = 1'b0;
    win    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ID_W'((int'(rr_q) + k) % NREQ);
      if (!accept && elig[idx]) begin
        accept = 1'b1;
        win    = idx;
      end
    end
    rr_d = accept ? ID_W'((int'(win) + 1) % NREQ) : rr_q;
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (win == ID_W'(i));
    end
  end

  assign tag_in = '{valid: accept, id: win};

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= LATENCY; k++) busy = busy | tag_q[k].valid;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_RUN:     if (drain_req)  st_d = ST_DRAIN;
      ST_DRAIN:   if (!busy)      st_d = ST_DRAINED;
      ST_DRAINED: if (!drain_req) st_d = ST_RUN;
      default:                    st_d = ST_RUN;
    endcase
  end

  assign drain_done = (st_q == ST_DRAINED);

  // Idle cycles feed zeros so the datapath sees a clean operand set.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_RUN;
      rr_q  <= '0;
      fma_a <= '0;
      fma_b <= '0;
      fma_c <= '0;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
    end else begin
      st_q     <= st_d;
      rr_q     <= rr_d;
      fma_a    <= accept ? a_v[win] : '0;
      fma_b    <= accept ? b_v[win] : '0;
      fma_c    <= accept ? c_v[win] : '0;
      tag_q[0] <= tag_in;
      for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

`ifdef UNUM_FMA_ARB_STATS_EN
  logic [31:0] issued_q, blocked_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q  <= '0;
      blocked_q <= '0;
    end else begin
      if (accept) issued_q <= issued_q + 32'd1;
      if ((|req_valid) && !accept) blocked_q <= blocked_q + 32'd1;
    end
  end

  assign stat_issued  = issued_q;
  assign stat_blocked = blocked_q;
`endif
endmodule

// File: doc/unum_fma_arbiter.md
# unum_fma_arbiter

Round-robin arbiter and sequencer that shares one 32-bit unum Type III multiply-adder pipeline (a*b+c, fixed latency, no stall) among NREQ requesters. It registers the winning operands into the pipeline, tracks each in-flight operation with a tag shift register aligned to the pipeline depth, and returns each result and NaN flag to the originating requester through a per-requester response FIFO. Credit-based issue guarantees that a result always has a FIFO slot. A drain state machine quiesces the pipeline on request.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- LATENCY, 10: register stages from multiply-adder input capture to `unum_o`/`NaN` valid.
- RSP_DEPTH, 2: entries per response FIFO; this is also the initial credit per requester.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  operation request per requester. Must not depend on req_ready.
- req_ready  out  NREQ  grant; at most one bit high per cycle; combinational.
- req_a, req_b, req_c  in  NREQ*32 each  operands, requester i in bits [32i+31:32i].
- fma_a, fma_b, fma_c  out  32 each  registered operands to the multiply-adder's unum1/unum2/unum3.
- fma_result  in  32  multiply-adder unum_o.
- fma_nan  in  1  multiply-adder NaN.
- rsp_valid  out  NREQ  response available (FIFO not empty).
- rsp_ready  in  NREQ  requester pops its response.
- rsp_data  out  NREQ*32  response head, per-requester slice.
- rsp_nan  out  NREQ  NaN flag of the head entry.
- drain_req  in  1  level; while high, block new issue and drain.
- drain_done  out  1  high while in DRAINED.

## Operation
- Eligible(i) = req_valid[i] & credit[i]!=0 & state==RUN.
- Round-robin: search starts at rr_ptr. The first eligible index wins and gets req_ready high that cycle. On accept, rr_ptr <= winner+1 mod NREQ. With no accept, rr_ptr holds.
- Accept edge: fma_a/b/c <= winner's operands; tag_pipe[0] <= {1, winner}; credit[winner]--.
- No accept: fma_a/b/c <= 0; tag_pipe[0].valid <= 0. Zero operands are harmless to the datapath.
- tag_pipe has LATENCY+1 entries (0..LATENCY) and shifts every cycle.
- When tag_pipe[LATENCY].valid: push {fma_nan, fma_result} into FIFO[tag].
- Pop on rsp_valid[i] & rsp_ready[i]; credit[i]++ on pop.
- Simultaneous issue and pop on the same requester: credit unchanged. Simultaneous push and pop on the same FIFO is legal.
- A credit of 0 blocks issue to that requester; the other requesters proceed.
- Credits never exceed RSP_DEPTH and the FIFOs cannot overflow. Either condition is a design error and must be covered by an assertion.
- Drain FSM, states RUN, DRAIN, DRAINED:
  - RUN -> DRAIN when drain_req.
  - DRAIN -> DRAINED when all tag_pipe valids are 0.
  - DRAINED -> RUN when !drain_req.
  - In DRAIN and DRAINED no grants are issued. FIFOs keep popping normally.
  - drain_req deasserted while in DRAIN: finish draining, pass through DRAINED for one cycle, then return to RUN.
- Unum special values (zero, Inf, NaN) pass through opaquely; the arbiter does not interpret data.

## Timing
- Reset values: req_ready=0, fma_a/b/c=0, rsp_valid=0, rsp_data=0, rsp_nan=0, drain_done=0, state=RUN, rr_ptr=0, every credit=RSP_DEPTH, all tags invalid, all FIFOs empty.
- Reset mid-operation discards every in-flight operation. Results still emerging from the datapath afterwards carry invalid tags and are ignored.
- Latency: accept at edge E0 -> FIFO push at E(LATENCY+1) -> rsp_valid high in the following cycle. Accept-to-response is LATENCY+1 cycles (11 at default).
- rsp_data/rsp_nan are first-word-fall-through, valid whenever rsp_valid is high.
- Throughput: one issue per cycle sustained across requesters. A single requester sustains RSP_DEPTH issues per LATENCY+2 cycles unless it pops immediately.

## Configuration
- UNUM_FMA_ARB_STATS_EN defined: adds two outputs.
  - stat_issued, 32 bits: wraps; incremented per accept.
  - stat_blocked, 32 bits: cycles with any req_valid high and no accept.
  - Both cleared by rst.
- Undefined: neither port nor counter exists, and there is no other behavioural difference.

## Structure
- Shared package unum_pkg:
  - UNUM_W=32.
  - FMA_LATENCY=10.
  - The drain state enum.
  - The tag struct {valid, id}.
- One sub-module: unum_rsp_fifo (parameterised depth, FWFT, 33-bit entry), instantiated NREQ times.

## Test plan
- Single op, requester 2: a=0x40000000, b=0x40000000, c=0 -> rsp_valid[2] rises 11 cycles after accept; rsp_data equals the multiply-adder result; no other rsp_valid rises.
- All four requesters held valid for 8 cycles, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3 on consecutive cycles; each requester receives 2 responses in issue order.
- Requester 0 valid, rsp_ready[0]=0 -> exactly 2 accepts, then req_ready[0] stays 0. Raise rsp_ready[0] for one pop -> next accept occurs one cycle later.
- drain_req pulsed with 3 ops in flight -> no grants while in DRAIN; drain_done rises one cycle after the last tag leaves; it falls one cycle after drain_req drops, and issue resumes.
- rst asserted 5 cycles after 4 accepts -> all rsp_valid stay 0 afterwards and credits read back as 2.
- fma_nan forced 1 on a tagged result for requester 1 -> rsp_nan[1]=1 with that entry only.
